// File: rtl/ex_alu_unit.sv
// Execute-stage ALU with a registered valid/ready output stage toward EX/MEM.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for code 8.
module ex_alu_unit #(
    parameter int WIDTH = 16,
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [TAGW-1:0]  tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [TAGW-1:0]  tag_out,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;

    // Illegal codes (and MUL when the multiplier is not built) fall to zero.
    function automatic logic [WIDTH-1:0] alu_single(
        input logic [3:0]       ctrl,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        case (ctrl)
            OP_ADD:  alu_single = a + b;
            OP_SUB:  alu_single = a - b;
            OP_AND:  alu_single = a & b;
            OP_OR:   alu_single = a | b;
            OP_XOR:  alu_single = a ^ b;
            OP_SLL:  alu_single = a << sh;
            OP_SRL:  alu_single = a >> sh;
            OP_SLT:  alu_single = ($signed(a) < $signed(b)) ?
                                  {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
            default: alu_single = {WIDTH{1'b0}};
        endcase
    endfunction

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [TAGW-1:0]  tag_q, tag_d;

    logic             out_free_s;
    logic             accept_s;
    logic             single_load_s;
    logic             mul_load_s;
    logic [WIDTH-1:0] mul_res_s;
    logic [TAGW-1:0]  mul_tag_s;
    logic [WIDTH-1:0] single_res_s;

    assign out_free_s   = !out_valid_q || out_ready;
    assign accept_s     = in_valid && in_ready;
    assign single_res_s = alu_single(alu_ctrl, op_a, op_b);

`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic [TAGW-1:0]  mtag_q, mtag_d;

    assign in_ready      = (state_q == S_IDLE) && out_free_s && !flush;
    assign busy          = (state_q != S_IDLE);
    assign single_load_s = accept_s && (alu_ctrl != OP_MUL);
    assign mul_load_s    = (state_q == S_DONE) && out_free_s && !flush;
    assign mul_res_s     = prod_q;
    assign mul_tag_s     = mtag_q;

    // Multiply FSM: one multiplier bit per cycle, only the low WIDTH product bits are kept.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        mtag_d   = mtag_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s && (alu_ctrl == OP_MUL)) begin
                        state_d  = S_MUL;
                        cnt_d    = SHW'(WIDTH - 1);
                        mcand_d  = op_a;
                        mplier_d = op_b;
                        prod_d   = {WIDTH{1'b0}};
                        mtag_d   = tag_in;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_MUL: begin
                    if (mplier_q[0]) begin
                        prod_d = prod_q + mcand_q;
                    end else begin
                        prod_d = prod_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if (cnt_q == {SHW{1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
                        state_d = S_MUL;
                    end
                end
                S_DONE: begin
                    if (out_free_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= {SHW{1'b0}};
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            prod_q   <= {WIDTH{1'b0}};
            mtag_q   <= {TAGW{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            mtag_q   <= mtag_d;
        end
    end
`else
    assign in_ready      = out_free_s && !flush;
    assign busy          = 1'b0;
    assign single_load_s = accept_s;
    assign mul_load_s    = 1'b0;
    assign mul_res_s     = {WIDTH{1'b0}};
    assign mul_tag_s     = {TAGW{1'b0}};
`endif

    // Output stage: flush wins, then a new load, then drain; otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        tag_d       = tag_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (single_load_s) begin
            out_valid_d = 1'b1;
            result_d    = single_res_s;
            zero_d      = (single_res_s == {WIDTH{1'b0}});
            tag_d       = tag_in;
        end else if (mul_load_s) begin
            out_valid_d = 1'b1;
            result_d    = mul_res_s;
            zero_d      = (mul_res_s == {WIDTH{1'b0}});
            tag_d       = mul_tag_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // EX/MEM boundary registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            zero_q      <= 1'b1;
            tag_q       <= {TAGW{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            tag_q       <= tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign tag_out   = tag_q;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Self-checking bench for ex_alu_unit: vector table, hand sequences and a result scoreboard.
module tb_ex_alu_unit;

    localparam int W  = 16;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    alu_ctrl;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [TW-1:0] tag_in;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          zero;
    logic [TW-1:0] tag_out;
    logic          busy;

    always #5 clk = ~clk;

    ex_alu_unit #(.WIDTH(W), .TAGW(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .tag_in(tag_in),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .tag_out(tag_out), .busy(busy)
    );

    typedef struct {
        logic [3:0]    ctrl;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [TW-1:0] tag;
        logic [W-1:0]  res;
        logic          z;
    } vec_t;

    typedef struct {
        logic [W-1:0]  res;
        logic          z;
        logic [TW-1:0] tag;
    } exp_t;

    vec_t          vecs[13];
    exp_t          sb[$];
    logic [W-1:0]  cur_res;
    logic          cur_z;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [3:0] c, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [3:0]  s;
        logic [31:0] p;
        s = b[3:0];
        p = 32'd0;
        case (c)
            4'd0: model = a + b;
            4'd1: model = a + (~b) + 16'd1;
            4'd2: model = a & b;
            4'd3: model = a | b;
            4'd4: model = a ^ b;
            4'd5: model = a << s;
            4'd6: model = a >> s;
            4'd7: model = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
`ifdef ALU_MUL_EN
            4'd8: begin p = a * b; model = p[15:0]; end
`endif
            default: model = 16'd0;
        endcase
    endfunction

    // Scoreboard: pop on output handshake, drop on flush, push on input accept.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got result 0x%0h with no expected entry", result);
                end else begin
                    e = sb.pop_front();
                    chk("sb_result", result, e.res);
                    chk("sb_zero", zero, e.z);
                    chk("sb_tag", tag_out, e.tag);
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back('{cur_res, cur_z, tag_in});
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] t, input logic [W-1:0] er, input logic ez,
                        output int waited);
        waited   = 0;
        in_valid = 1'b1;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        tag_in   = t;
        cur_res  = er;
        cur_z    = ez;
        #3;
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            #3;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready 0 after %0d cycles, required 1", waited);
        end
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        logic [3:0] c;
        logic [W-1:0] a, b, r;

        vecs[0]  = '{4'd2, 16'hF0F0, 16'h0FF0, 4'd1, 16'h00F0, 1'b0};
        vecs[1]  = '{4'd3, 16'hF000, 16'h000F, 4'd2, 16'hF00F, 1'b0};
        vecs[2]  = '{4'd4, 16'hAAAA, 16'hFFFF, 4'd3, 16'h5555, 1'b0};
        vecs[3]  = '{4'd5, 16'h0001, 16'h0013, 4'd4, 16'h0008, 1'b0};
        vecs[4]  = '{4'd6, 16'h8000, 16'h000F, 4'd5, 16'h0001, 1'b0};
        vecs[5]  = '{4'd7, 16'hFFFF, 16'h0001, 4'd6, 16'h0001, 1'b0};
        vecs[6]  = '{4'd7, 16'h0001, 16'hFFFF, 4'd7, 16'h0000, 1'b1};
        vecs[7]  = '{4'd1, 16'h0000, 16'h0001, 4'd8, 16'hFFFF, 1'b0};
        vecs[8]  = '{4'd9, 16'h1234, 16'h5678, 4'd9, 16'h0000, 1'b1};
        vecs[9]  = '{4'd15, 16'hFFFF, 16'hFFFF, 4'd10, 16'h0000, 1'b1};
        vecs[10] = '{4'd5, 16'hFFFF, 16'h0010, 4'd11, 16'hFFFF, 1'b0};
        vecs[11] = '{4'd0, 16'hFFFF, 16'h0001, 4'd12, 16'h0000, 1'b1};
        vecs[12] = '{4'd6, 16'h1234, 16'hFFF4, 4'd13, 16'h0123, 1'b0};

        rst = 1'b1; in_valid = 1'b0; alu_ctrl = 4'd0; op_a = 16'd0; op_b = 16'd0;
        tag_in = 4'd0; flush = 1'b0; out_ready = 1'b1; cur_res = 16'd0; cur_z = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 16'h0000);
        chk("rst_zero", zero, 1);
        chk("rst_tag", tag_out, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // ADD wrap then SUB to zero, back to back
        send(4'd0, 16'h7FFF, 16'h0001, 4'd1, 16'h8000, 1'b0, w);
        chk("add_valid", out_valid, 1);
        chk("add_result", result, 16'h8000);
        chk("add_zero", zero, 0);
        send(4'd1, 16'h0005, 16'h0005, 4'd2, 16'h0000, 1'b1, w);
        chk("sub_b2b_wait", w, 0);
        chk("sub_result", result, 16'h0000);
        chk("sub_zero", zero, 1);

        for (int i = 0; i < 13; i++) begin
            send(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].res, vecs[i].z, w);
            chk($sformatf("vec%0d_result", i), result, vecs[i].res);
            chk($sformatf("vec%0d_zero", i), zero, vecs[i].z);
            chk($sformatf("vec%0d_tag", i), tag_out, vecs[i].tag);
        end
        in_valid = 1'b0;
        @(negedge clk);

        // Output hold under back-pressure
        out_ready = 1'b0;
        send(4'd0, 16'h0002, 16'h0002, 4'd3, 16'h0004, 1'b0, w);
        in_valid = 1'b0;
        repeat (3) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_result", result, 16'h0004);
            chk("hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        send(4'd0, 16'h0003, 16'h0003, 4'd4, 16'h0006, 1'b0, w);
        chk("hold_resume_wait", w, 0);
        chk("hold_resume_result", result, 16'h0006);
        in_valid = 1'b0;
        @(negedge clk);

        // Flush discards a pending result but keeps result/tag
        out_ready = 1'b0;
        send(4'd4, 16'h00FF, 16'h0F0F, 4'd5, 16'h0FF0, 1'b0, w);
        in_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_keep_result", result, 16'h0FF0);
        chk("flush_keep_tag", tag_out, 5);
        out_ready = 1'b1;
        @(negedge clk);

`ifdef ALU_MUL_EN
        send(4'd8, 16'h0003, 16'h0005, 4'd6, 16'h000F, 1'b0, w);
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("mul_busy_c%0d", i), busy, 1);
            chk($sformatf("mul_in_ready_c%0d", i), in_ready, 0);
            chk($sformatf("mul_valid_c%0d", i), out_valid, 0);
            @(negedge clk);
        end
        chk("mul_done_busy", busy, 1);
        chk("mul_done_valid", out_valid, 0);
        @(negedge clk);
        chk("mul_out_valid", out_valid, 1);
        chk("mul_result", result, 16'h000F);
        chk("mul_tag", tag_out, 6);
        chk("mul_busy_end", busy, 0);

        send(4'd8, 16'h0007, 16'h0009, 4'd7, 16'h003F, 1'b0, w);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("mulflush_busy", busy, 0);
        chk("mulflush_valid", out_valid, 0);
        chk("mulflush_in_ready", in_ready, 1);
        send(4'd0, 16'h0001, 16'h0001, 4'd8, 16'h0002, 1'b0, w);
        chk("mulflush_add_valid", out_valid, 1);
        chk("mulflush_add_result", result, 16'h0002);
        in_valid = 1'b0;

        send(4'd8, 16'h0011, 16'h0013, 4'd9, 16'h0143, 1'b0, w);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mulrst_busy", busy, 0);
        chk("mulrst_valid", out_valid, 0);
        chk("mulrst_result", result, 16'h0000);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`else
        send(4'd8, 16'h0003, 16'h0005, 4'd6, 16'h0000, 1'b1, w);
        chk("mul_off_result", result, 16'h0000);
        chk("mul_off_zero", zero, 1);
        chk("mul_off_busy", busy, 0);
        in_valid = 1'b0;
        @(negedge clk);
`endif

        // Reset asserted mid-stream, checked before any clock edge
        out_ready = 1'b0;
        send(4'd0, 16'h0005, 16'h0006, 4'd10, 16'h000B, 1'b0, w);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_result", result, 16'h0000);
        chk("midrst_zero", zero, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_tag", tag_out, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        // Random ops with intermittent back-pressure
        for (int i = 0; i < 24; i++) begin
            out_ready = 1'b0;
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            out_ready = 1'b1;
            c = 4'($urandom_range(0, 15));
            a = 16'($urandom);
            b = 16'($urandom);
            r = model(c, a, b);
            send(c, a, b, 4'(i), r, (r == 16'd0), w);
        end
        in_valid = 1'b0;

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
